// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/select bundle between the four requesters and the 4:1 mux arbiter.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       S1;
  logic       S0;
  logic       busy;

  modport master (output req, input gnt, S1, S0, busy);
  modport slave  (input req, output gnt, S1, S0, busy);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux selects, with a bounded grant tenure
// so a persistent requester cannot starve the others.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  mux4_rr_arbiter_if.slave         bus
);

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned HOLD_W  = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    ptr;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [NUM_REQ-1:0]  gnt_q;
  logic                busy_q;

  // First set bit scanning p, p+1, ... modulo 4; MSB of result flags a winner.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   p);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = p + IDX_W'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [NUM_REQ-1:0] others;
  logic [IDX_W:0]     win_any;
  logic [IDX_W:0]     win_oth;
  logic               at_max;
  logic               do_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               go_idle;
  logic               reload;
  logic               inc;

  assign others  = bus.req & ~(NUM_REQ'(1) << owner);
  assign win_any = rr_pick(bus.req, ptr);
  assign win_oth = rr_pick(others, ptr);
  assign at_max  = (hold_cnt == HOLD_W'(MAX_HOLD));

  // Next-action decode: release, forced rotation on expiry, reload, or extend tenure.
  always_comb begin
    do_grant  = 1'b0;
    grant_idx = win_any[IDX_W-1:0];
    go_idle   = 1'b0;
    reload    = 1'b0;
    inc       = 1'b0;
    case (state)
      IDLE: do_grant = win_any[IDX_W];
      GRANT: begin
        if (!bus.req[owner]) begin
          if (win_any[IDX_W]) do_grant = 1'b1;
          else                go_idle  = 1'b1;
        end else if (at_max) begin
          if (win_oth[IDX_W]) begin
            do_grant  = 1'b1;
            grant_idx = win_oth[IDX_W-1:0];
          end else begin
            reload = 1'b1;
          end
        end else begin
          inc = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (do_grant) begin
      state    <= GRANT;
      owner    <= grant_idx;
      ptr      <= grant_idx + IDX_W'(1);
      hold_cnt <= HOLD_W'(1);
      gnt_q    <= NUM_REQ'(1) << grant_idx;
      busy_q   <= 1'b1;
    end else if (go_idle) begin
      state    <= IDLE;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (reload) begin
      hold_cnt <= HOLD_W'(1);
    end else if (inc) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // owner is a register, so the selects carry no combinational path from req.
  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.S1   = owner[1];
  assign bus.S0   = owner[0];

endmodule
